mem_port_arbiter: RTL and testbench

//  Shares the single external memory port between instruction fetch (I) and

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one external memory port between instruction
// fetch (I) and data access (D). One requester is granted at a time with
// round-robin on contention. A watchdog aborts accesses that never complete.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // Instruction fetch side
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    // Data access side
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    // External memory port
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // Pipeline control
    output logic              stall,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam bit          WD_EN = (TIMEOUT != 0);
    // Last busy-cycle count before abort; irrelevant when the watchdog is off
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1 = D was granted most recently
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_cen_q, mem_cen_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;

    logic grant_d, grant_i, timeout_hit, busy_done;

    // Arbitration: D wins on contention unless it was the last one served
    always_comb begin
        grant_d     = (state_q == StIdle) && d_req && (!i_req || !last_d_q);
        grant_i     = (state_q == StIdle) && i_req && !grant_d;
        timeout_hit = WD_EN && (cnt_q == CNT_LAST);
        busy_done   = mem_ready || timeout_hit;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d = StBusyD;
                end else if (grant_i) begin
                    state_d = StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                if (busy_done) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output/datapath next values: grant loads the port, completion or abort
    // captures data and raises a one-cycle ready in RESP
    always_comb begin
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_cen_d   = mem_cen_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    mem_cen_d   = 1'b1;
                    mem_wen_d   = d_wen;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    last_d_d    = 1'b1;
                    cnt_d       = '0;
                end else if (grant_i) begin
                    mem_cen_d   = 1'b1;
                    mem_wen_d   = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    last_d_d    = 1'b0;
                    cnt_d       = '0;
                end
            end
            StBusyI, StBusyD: begin
                if (busy_done) begin
                    mem_cen_d = 1'b0;
                    if (!mem_ready) begin
                        err_d = 1'b1;
                    end
                    if (state_q == StBusyI) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        d_ready_d = 1'b1;
                        // Writes return zero; aborted accesses return zero
                        d_rdata_d = (mem_ready && !mem_wen_q) ? mem_rdata : '0;
                    end
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_d_q    <= 1'b0;
            cnt_q       <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_cen_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_cen_q   <= mem_cen_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    // Port mapping; stall freezes the pipeline while a request is unserved
    always_comb begin
        i_ready   = i_ready_q;
        d_ready   = d_ready_q;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
        mem_cen   = mem_cen_q;
        mem_wen   = mem_wen_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        err       = err_q;
        stall     = (i_req && !i_ready_q) || (d_req && !d_ready_q);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand
// sequences for back-to-back, watchdog and mid-transaction reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wen, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ready, d_ready, mem_cen, mem_wen, stall, err;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_wen    (d_wen),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_cen  (mem_cen),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall    (stall),
        .err      (err)
    );

    typedef struct packed {
        logic        rst_n, i_req;
        logic [31:0] i_addr;
        logic        d_req, d_wen;
        logic [31:0] d_addr, d_wdata;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_i_ready, e_d_ready;
        logic [31:0] e_i_rdata, e_d_rdata;
        logic        e_cen, e_wen;
        logic [31:0] e_addr, e_wdata;
        logic        e_stall, e_err;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
        input logic mr, input logic [31:0] md,
        input logic eir, input logic edr, input logic [31:0] eid, input logic [31:0] edd,
        input logic ec, input logic ew, input logic [31:0] ea, input logic [31:0] ewd,
        input logic es, input logic ee);
        vec_t v;
        v = {r, ir, ia, dr, dw, da, dd, mr, md, eir, edr, eid, edd, ec, ew, ea, ewd, es, ee};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 22;
    vec_t vt[NV];

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        // rst ireq iaddr dreq dwen daddr dwdata mrdy mrdata |
        // i_rdy d_rdy i_rdata d_rdata cen wen addr wdata stall err
        vt[0]  = mk(0,0,'h0, 0,0,'h0,'h0, 0,'h0,        0,0,'h0,'h0, 0,0,'h0,'h0, 0,0);
        // single fetch, mem_ready on second busy cycle
        vt[1]  = mk(1,1,'h10,0,0,'h0,'h0, 0,'h0,        0,0,'h0,'h0, 1,0,'h10,'h0, 1,0);
        vt[2]  = mk(1,1,'h10,0,0,'h0,'h0, 0,'h0,        0,0,'h0,'h0, 1,0,'h10,'h0, 1,0);
        vt[3]  = mk(1,1,'h10,0,0,'h0,'h0, 1,'hDEADBEEF, 1,0,'hDEADBEEF,'h0, 0,0,'h10,'h0, 0,0);
        vt[4]  = mk(1,0,'h10,0,0,'h0,'h0, 0,'h0,        0,0,'hDEADBEEF,'h0, 0,0,'h10,'h0, 0,0);
        // stray mem_ready in idle
        vt[5]  = mk(1,0,'h0, 0,0,'h0,'h0, 1,'h12345678, 0,0,'hDEADBEEF,'h0, 0,0,'h10,'h0, 0,0);
        // contention right after reset: D write first, then I
        vt[6]  = mk(0,0,'h0, 0,0,'h0,'h0, 0,'h0,        0,0,'h0,'h0, 0,0,'h0,'h0, 0,0);
        vt[7]  = mk(1,1,'h20,1,1,'h40,'h55, 0,'h0,      0,0,'h0,'h0, 1,1,'h40,'h55, 1,0);
        vt[8]  = mk(1,1,'h20,1,1,'h40,'h55, 1,'h99,     0,1,'h0,'h0, 0,1,'h40,'h55, 1,0);
        vt[9]  = mk(1,1,'h20,0,0,'h0,'h0, 0,'h0,        0,0,'h0,'h0, 0,1,'h40,'h55, 1,0);
        vt[10] = mk(1,1,'h20,0,0,'h0,'h0, 0,'h0,        0,0,'h0,'h0, 1,0,'h20,'h0, 1,0);
        vt[11] = mk(1,1,'h20,0,0,'h0,'h0, 1,'hA5A5A5A5, 1,0,'hA5A5A5A5,'h0, 0,0,'h20,'h0, 0,0);
        vt[12] = mk(1,0,'h0, 0,0,'h0,'h0, 0,'h0,        0,0,'hA5A5A5A5,'h0, 0,0,'h20,'h0, 0,0);
        // lone D read, then a pair: I must win now
        vt[13] = mk(1,0,'h0, 1,0,'h44,'h0, 0,'h0,       0,0,'hA5A5A5A5,'h0, 1,0,'h44,'h0, 1,0);
        vt[14] = mk(1,0,'h0, 1,0,'h44,'h0, 1,'h11,      0,1,'hA5A5A5A5,'h11, 0,0,'h44,'h0, 0,0);
        vt[15] = mk(1,0,'h0, 0,0,'h0,'h0, 0,'h0,        0,0,'hA5A5A5A5,'h11, 0,0,'h44,'h0, 0,0);
        vt[16] = mk(1,1,'h30,1,0,'h48,'h0, 0,'h0,       0,0,'hA5A5A5A5,'h11, 1,0,'h30,'h0, 1,0);
        vt[17] = mk(1,1,'h30,1,0,'h48,'h0, 1,'h22,      1,0,'h22,'h11, 0,0,'h30,'h0, 1,0);
        vt[18] = mk(1,0,'h0, 1,0,'h48,'h0, 0,'h0,       0,0,'h22,'h11, 0,0,'h30,'h0, 1,0);
        vt[19] = mk(1,0,'h0, 1,0,'h48,'h0, 0,'h0,       0,0,'h22,'h11, 1,0,'h48,'h0, 1,0);
        vt[20] = mk(1,0,'h0, 1,0,'h48,'h0, 1,'h33,      0,1,'h22,'h33, 0,0,'h48,'h0, 0,0);
        vt[21] = mk(1,0,'h0, 0,0,'h0,'h0, 0,'h0,        0,0,'h22,'h33, 0,0,'h48,'h0, 0,0);

        for (int k = 0; k < NV; k++) begin
            rst_n = vt[k].rst_n;  i_req = vt[k].i_req;  i_addr = vt[k].i_addr;
            d_req = vt[k].d_req;  d_wen = vt[k].d_wen;  d_addr = vt[k].d_addr;
            d_wdata = vt[k].d_wdata;  mem_ready = vt[k].mem_ready;
            mem_rdata = vt[k].mem_rdata;
            step();
            chk($sformatf("v%0d i_ready", k),   i_ready,   vt[k].e_i_ready);
            chk($sformatf("v%0d d_ready", k),   d_ready,   vt[k].e_d_ready);
            chk($sformatf("v%0d i_rdata", k),   i_rdata,   vt[k].e_i_rdata);
            chk($sformatf("v%0d d_rdata", k),   d_rdata,   vt[k].e_d_rdata);
            chk($sformatf("v%0d mem_cen", k),   mem_cen,   vt[k].e_cen);
            chk($sformatf("v%0d mem_wen", k),   mem_wen,   vt[k].e_wen);
            chk($sformatf("v%0d mem_addr", k),  mem_addr,  vt[k].e_addr);
            chk($sformatf("v%0d mem_wdata", k), mem_wdata, vt[k].e_wdata);
            chk($sformatf("v%0d stall", k),     stall,     vt[k].e_stall);
            chk($sformatf("v%0d err", k),       err,       vt[k].e_err);
        end

        // Back-to-back D reads held on d_req: one pulse and one idle gap each
        d_req = 1'b1; d_wen = 1'b0; d_wdata = '0; mem_ready = 1'b0;
        for (int a = 0; a < 3; a++) begin
            d_addr = 32'(a * 4);
            step();
            n = 0;
            while (!mem_cen && n < 10) begin
                step();
                n++;
            end
            chk("b2b grant", mem_cen, 1'b1);
            chk("b2b mem_addr", mem_addr, 32'(a * 4));
            mem_ready = 1'b1;
            mem_rdata = 32'hCAFE0000 | 32'(a * 4);
            step();
            chk("b2b d_ready", d_ready, 1'b1);
            chk("b2b d_rdata", d_rdata, 32'hCAFE0000 | 32'(a * 4));
            mem_ready = 1'b0;
            if (a == 2) d_req = 1'b0;
            step();
            chk("b2b gap d_ready", d_ready, 1'b0);
            chk("b2b gap mem_cen", mem_cen, 1'b0);
        end

        // Watchdog abort with TIMEOUT=8, then a normal access with err sticky
        i_req = 1'b1; i_addr = 32'h100; mem_ready = 1'b0;
        step();
        chk("to grant", mem_cen, 1'b1);
        chk("to err before", err, 1'b0);
        n = 0;
        while (!i_ready && n < 20) begin
            step();
            n++;
        end
        chk("to i_ready", i_ready, 1'b1);
        chk("to busy cycles", 32'(n == 7 || n == 8), 32'd1);
        chk("to i_rdata", i_rdata, 32'h0);
        chk("to err", err, 1'b1);
        chk("to mem_cen", mem_cen, 1'b0);
        i_req = 1'b0;
        step();
        chk("to pulse end", i_ready, 1'b0);
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h200;
        step();
        chk("after to grant", mem_cen, 1'b1);
        mem_ready = 1'b1; mem_rdata = 32'h5A;
        step();
        chk("after to d_ready", d_ready, 1'b1);
        chk("after to d_rdata", d_rdata, 32'h5A);
        chk("after to err sticky", err, 1'b1);
        mem_ready = 1'b0; d_req = 1'b0;
        step();
        chk("after to err held", err, 1'b1);

        // Reset in the middle of a D write: access dropped, no ready pulse
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h80; d_wdata = 32'h77;
        step();
        chk("rst grant", mem_cen, 1'b1);
        chk("rst grant wen", mem_wen, 1'b1);
        step();
        rst_n = 1'b0;
        step();
        chk("rst mem_cen", mem_cen, 1'b0);
        chk("rst d_ready", d_ready, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst d_rdata", d_rdata, 32'h0);
        rst_n = 1'b1; d_req = 1'b0; mem_ready = 1'b1;
        step();
        chk("rst post d_ready", d_ready, 1'b0);
        chk("rst post mem_cen", mem_cen, 1'b0);
        mem_ready = 1'b0;
        step();
        chk("rst post2 d_ready", d_ready, 1'b0);
        chk("rst post stall", stall, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
